// File: rtl/evo_harness_pkg.sv
// evo_harness_pkg: shared types and defaults for the evolved-circuit harness stages.
//   evo_state_e       : sweep FSM states
//   SETTLE_CYCLES_DEF : default wait after applying a vector
//   SAMPLE_CYCLES_DEF : default output sampling window length
//   max_int()         : helper used to size shared timers
package evo_harness_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } evo_state_e;

  localparam int SETTLE_CYCLES_DEF = 16;
  localparam int SAMPLE_CYCLES_DEF = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/evo_sync2.sv
// evo_sync2: two-flop synchronizer for a single asynchronous bit.
//   clk  : destination clock
//   rst  : asynchronous active-high reset, both flops clear to 0
//   d_i  : asynchronous input
//   q_o  : synchronized output, two cycles of latency
module evo_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/evo_stimulus_sampler.sv
// evo_stimulus_sampler: sweeps every input vector of an evolved circuit, waits a
// settle window, samples the synchronized output and scores it against a truth table.
//   clk, rst        : system clock, asynchronous active-high reset
//   start           : begin a sweep (accepted only when idle)
//   expected        : expected truth table, captured on start
//   busy, done      : sweep in progress / one-cycle completion pulse
//   dut_in, dut_out : vector to the circuit under test / its raw async output
//   result          : first sampled value per vector
//   unstable        : output moved within the sample window, per vector
//   mismatch_count  : vectors where result differs from expected or unstable
//   toggle_count    : present only with EVO_SAMPLER_TOGGLE_CNT_EN; saturating count
//                     of output transitions inside sample windows
module evo_stimulus_sampler
  import evo_harness_pkg::*;
#(
  parameter int IN_WIDTH      = 2,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int SAMPLE_CYCLES = SAMPLE_CYCLES_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [(1<<IN_WIDTH)-1:0] expected,
  output logic                     busy,
  output logic                     done,
  output logic [IN_WIDTH-1:0]      dut_in,
  input  logic                     dut_out,
  output logic [(1<<IN_WIDTH)-1:0] result,
  output logic [(1<<IN_WIDTH)-1:0] unstable,
`ifdef EVO_SAMPLER_TOGGLE_CNT_EN
  output logic [15:0]              toggle_count,
`endif
  output logic [IN_WIDTH:0]        mismatch_count
);

  localparam int NVEC = 1 << IN_WIDTH;
  localparam int TW   = $clog2(max_int(SETTLE_CYCLES, SAMPLE_CYCLES) + 1);

  evo_state_e          state_q;
  logic [IN_WIDTH-1:0] vec_q;
  logic [IN_WIDTH-1:0] dut_in_q;
  logic [TW-1:0]       timer_q;
  logic [NVEC-1:0]     exp_q;
  logic [NVEC-1:0]     result_q;
  logic [NVEC-1:0]     unstable_q;
  logic [IN_WIDTH:0]   mm_q;
  logic                busy_q;
  logic                done_q;
  logic                first_val_q;
  logic                sync_prev_q;
  logic                sync_out;

  logic                first_cyc;
  logic [NVEC-1:0]     result_d;
  logic [NVEC-1:0]     unstable_d;
  logic [IN_WIDTH:0]   mm_d;

  evo_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (dut_out),
    .q_o (sync_out)
  );

  assign first_cyc = (timer_q == TW'(SAMPLE_CYCLES - 1));

  // Next values of the score vectors are formed here so the final sample cycle
  // can fold into mismatch_count on the same edge that raises done.
  always_comb begin
    result_d   = result_q;
    unstable_d = unstable_q;
    if (state_q == ST_SAMPLE) begin
      if (first_cyc) begin
        result_d[vec_q] = sync_out;
      end else if (sync_out != first_val_q) begin
        unstable_d[vec_q] = 1'b1;
      end
    end
  end

  always_comb begin
    mm_d = '0;
    for (int i = 0; i < NVEC; i++) begin
      mm_d = mm_d + {{IN_WIDTH{1'b0}}, ((result_d[i] ^ exp_q[i]) | unstable_d[i])};
    end
  end

`ifdef EVO_SAMPLER_TOGGLE_CNT_EN
  logic [15:0] toggle_q;
  assign toggle_count = toggle_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      vec_q       <= '0;
      dut_in_q    <= '0;
      timer_q     <= '0;
      exp_q       <= '0;
      result_q    <= '0;
      unstable_q  <= '0;
      mm_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      first_val_q <= 1'b0;
      sync_prev_q <= 1'b0;
`ifdef EVO_SAMPLER_TOGGLE_CNT_EN
      toggle_q    <= '0;
`endif
    end else begin
      done_q      <= 1'b0;
      sync_prev_q <= sync_out;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q    <= ST_APPLY;
            vec_q      <= '0;
            exp_q      <= expected;
            result_q   <= '0;
            unstable_q <= '0;
            mm_q       <= '0;
            busy_q     <= 1'b1;
`ifdef EVO_SAMPLER_TOGGLE_CNT_EN
            toggle_q   <= '0;
`endif
          end
        end
        ST_APPLY: begin
          dut_in_q <= vec_q;
          timer_q  <= TW'(SETTLE_CYCLES - 1);
          state_q  <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (timer_q == '0) begin
            timer_q <= TW'(SAMPLE_CYCLES - 1);
            state_q <= ST_SAMPLE;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        ST_SAMPLE: begin
          result_q   <= result_d;
          unstable_q <= unstable_d;
          if (first_cyc) begin
            first_val_q <= sync_out;
          end
`ifdef EVO_SAMPLER_TOGGLE_CNT_EN
          // Only transitions inside the window count; the edge into it does not.
          if (!first_cyc && (sync_out != sync_prev_q) && (toggle_q != 16'hFFFF)) begin
            toggle_q <= toggle_q + 16'd1;
          end
`endif
          if (timer_q == '0) begin
            if (&vec_q) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              mm_q    <= mm_d;
            end else begin
              vec_q   <= vec_q + 1'b1;
              state_q <= ST_APPLY;
            end
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign dut_in         = dut_in_q;
  assign result         = result_q;
  assign unstable       = unstable_q;
  assign mismatch_count = mm_q;

endmodule

// File: tb/tb_evo_stimulus_sampler.sv
module tb_evo_stimulus_sampler;

  localparam int SWEEP_CYCLES = 4 * (1 + 16 + 8);

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] expected;
  logic       busy;
  logic       done;
  logic [1:0] dut_in;
  logic       dut_out;
  logic [3:0] result;
  logic [3:0] unstable;
  logic [2:0] mismatch_count;
`ifdef EVO_SAMPLER_TOGGLE_CNT_EN
  logic [15:0] toggle_count;
`endif

  int checks   = 0;
  int failures = 0;

  // Behavioural circuit-under-test: 0 = truth table, 1 = oscillate on vector 3,
  // 2 = truth table with an inverted glitch early in each vector's settle window.
  int         mode = 0;
  logic [3:0] func = 4'b0000;
  logic       tog  = 1'b0;
  int         gcnt = 0;
  logic       glitch;

  always #5 clk = ~clk;

  evo_stimulus_sampler dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .expected       (expected),
    .busy           (busy),
    .done           (done),
    .dut_in         (dut_in),
    .dut_out        (dut_out),
    .result         (result),
    .unstable       (unstable),
`ifdef EVO_SAMPLER_TOGGLE_CNT_EN
    .toggle_count   (toggle_count),
`endif
    .mismatch_count (mismatch_count)
  );

  always @(negedge clk) begin
    if (dut_in == 2'd3) tog <= ~tog;
    else                tog <= 1'b0;
    if (busy) gcnt <= gcnt + 1;
    else      gcnt <= 0;
  end

  always_comb begin
    glitch = ((gcnt % 25) >= 1) && ((gcnt % 25) <= 5);
    case (mode)
      0:       dut_out = func[dut_in];
      1:       dut_out = (dut_in == 2'd3) ? tog : 1'b0;
      default: dut_out = func[dut_in] ^ glitch;
    endcase
  end

  task automatic chk(input string tag, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_dut_in"}, dut_in, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_unstable"}, unstable, 0);
    chk({tag, "_mismatch"}, mismatch_count, 0);
  endtask

  // One sweep with optional disturbance: repulse_at re-asserts start in that busy
  // cycle, rst_at aborts with reset in that busy cycle (0 = none).
  task automatic run_sweep(input int md, input logic [3:0] fn, input logic [3:0] ex,
                           input int repulse_at, input int rst_at);
    int         cyc;
    int         dn;
    logic [3:0] exp_res;
    logic [3:0] exp_uns;
    logic [3:0] mask;
    int         exp_mm;

    mode = md;
    func = fn;
    expected = ex;
    exp_res = (md == 1) ? 4'b0000 : fn;
    exp_uns = (md == 1) ? 4'b1000 : 4'b0000;
    mask    = (md == 1) ? 4'b0111 : 4'b1111;
    exp_mm  = $countones((exp_res ^ ex) | exp_uns);

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 200) begin
      cyc++;
      start = (cyc == repulse_at);
      if (cyc == rst_at) begin
        rst = 1'b1;
        #1;
        check_all_zero("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        repeat (120) begin
          @(negedge clk);
          if (done) dn++;
        end
        chk("rst_no_done", dn, 0);
        chk("rst_idle_busy", busy, 0);
        return;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("busy_cycles", cyc, SWEEP_CYCLES);
    chk("done_at_fall", done, 1);
    chk("result", result & mask, exp_res & mask);
    chk("unstable", unstable, exp_uns);
    chk("mismatch", mismatch_count, exp_mm);
`ifdef EVO_SAMPLER_TOGGLE_CNT_EN
    if (md == 1) chk("toggle_ge7", int'(toggle_count >= 16'd7), 1);
    else         chk("toggle_zero", toggle_count, 0);
`endif
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    repeat (4) @(negedge clk);
    chk("hold_result", result & mask, exp_res & mask);
    chk("hold_mismatch", mismatch_count, exp_mm);
    chk("hold_dut_in", dut_in, 3);
    chk("hold_idle", busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    expected = 4'b0000;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("post_reset");

    run_sweep(0, 4'b1110, 4'b1110, 0, 0);
    run_sweep(0, 4'b1110, 4'b1111, 0, 0);
    run_sweep(1, 4'b0000, 4'b0000, 0, 0);
    run_sweep(0, 4'b1110, 4'b1110, 40, 0);
    run_sweep(0, 4'b1110, 4'b1110, 0, 60);
    run_sweep(0, 4'b1110, 4'b1110, 0, 0);
    run_sweep(2, 4'b1110, 4'b1110, 0, 0);

    for (int i = 0; i < 6; i++) begin
      logic [3:0] rf;
      logic [3:0] re;
      rf = 4'($urandom);
      re = 4'($urandom);
      run_sweep(($urandom_range(0, 1) == 0) ? 0 : 2, rf, re, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
